// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: N-master to 1-slave Wishbone classic arbiter.
// Supports round-robin or fixed priority, holds the grant for as long as the
// winning master keeps CYC high, and can end a stalled cycle with an ERR.

module wb_arbiter_n #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_MASTERS-1:0]                m_cyc_i,
    input  logic [N_MASTERS-1:0]                m_stb_i,
    input  logic [N_MASTERS-1:0]                m_we_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
    input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic [N_MASTERS-1:0]                m_ack_o,
    output logic [N_MASTERS-1:0]                m_err_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic                                s_we_o,
    output logic [ADDR_WIDTH-1:0]               s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [DATA_WIDTH/8-1:0]             s_sel_o,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    output logic [N_MASTERS-1:0]                grant_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // The abort decision is taken on the cycle the count would reach TIMEOUT,
    // so the error lands on the cycle right after TIMEOUT stalled beats.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [N_MASTERS-1:0] grant;
    logic [GW-1:0]        last_grant;
    logic [CW-1:0]        count;
    logic [N_MASTERS-1:0] req;
    logic                 any_req;
    logic [GW-1:0]        winner;
    logic                 busy;
    logic                 abort;
    logic                 cur_cyc;
    logic                 stall;
    logic                 timeout_hit;

    // last_grant always names the master currently holding the bus while BUSY,
    // so it doubles as the select for the slave-side mux.
    assign req      = m_cyc_i & m_stb_i;
    assign any_req  = |req;
    assign busy     = (state == ST_BUSY);
    assign abort    = (state == ST_ABORT);
    assign cur_cyc  = m_cyc_i[last_grant];

    assign s_cyc_o  = busy & cur_cyc;
    assign s_stb_o  = busy & m_stb_i[last_grant];
    assign s_we_o   = busy & m_we_i[last_grant];
    assign s_adr_o  = busy ? m_adr_i[int'(last_grant)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_dat_o  = busy ? m_dat_i[int'(last_grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign s_sel_o  = busy ? m_sel_i[int'(last_grant)*SEL_WIDTH +: SEL_WIDTH] : '0;

    assign m_dat_o  = s_dat_i;
    assign m_ack_o  = busy ? (grant & {N_MASTERS{s_ack_i}}) : '0;
    assign m_err_o  = busy  ? (grant & {N_MASTERS{s_err_i}}) :
                      abort ? grant : '0;
    assign grant_o  = grant;

    assign stall       = s_stb_o & ~s_ack_i & ~s_err_i;
    assign timeout_hit = (TIMEOUT != 0) && busy && cur_cyc && stall && (count == CNT_LAST);

    // Pick the next owner: rotating search after the last owner, or lowest index.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (ARB_MODE == 1) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) winner = GW'(i);
            end
        end else begin
            for (int i = 1; i <= N_MASTERS; i++) begin
                idx = int'(last_grant) + i;
                if (idx >= N_MASTERS) idx = idx - N_MASTERS;
                if (!found && req[idx]) begin
                    winner = GW'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    // Next-state decode; dropping CYC releases the bus even mid-beat.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (any_req) state_next = ST_BUSY;
            ST_BUSY: begin
                if (!cur_cyc)         state_next = ST_IDLE;
                else if (timeout_hit) state_next = ST_ABORT;
            end
            ST_ABORT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, grant register and round-robin history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= GW'(N_MASTERS - 1);
        end else begin
            state <= state_next;
            if (state == ST_IDLE && any_req) begin
                grant      <= N_MASTERS'(1) << winner;
                last_grant <= winner;
            end else if (state_next == ST_IDLE) begin
                grant <= '0;
            end
        end
    end

    // Stall counter: counts unanswered strobes, clears on any response or exit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (busy && stall && state_next == ST_BUSY) begin
            if (TIMEOUT != 0 && count != CNT_MAX) count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// tb_wb_arbiter_n: directed bench for wb_arbiter_n. Three instances share the
// master/slave stimulus: A round-robin T=16, B fixed priority T=16, C round-robin
// with the timeout disabled. Each test resets all three and checks one of them.

module tb_wb_arbiter_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  m_cyc = '0;
    logic [2:0]  m_stb = '0;
    logic [2:0]  m_we = '0;
    logic [95:0] m_adr = '0;
    logic [95:0] m_dat = '0;
    logic [11:0] m_sel = '1;
    logic [31:0] s_dat = '0;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;

    logic [31:0] m_dat_a, m_dat_b, m_dat_c;
    logic [2:0]  m_ack_a, m_ack_b, m_ack_c;
    logic [2:0]  m_err_a, m_err_b, m_err_c;
    logic        s_cyc_a, s_cyc_b, s_cyc_c;
    logic        s_stb_a, s_stb_b, s_stb_c;
    logic        s_we_a, s_we_b, s_we_c;
    logic [31:0] s_adr_a, s_adr_b, s_adr_c;
    logic [31:0] s_dato_a, s_dato_b, s_dato_c;
    logic [3:0]  s_sel_a, s_sel_b, s_sel_c;
    logic [2:0]  grant_a, grant_b, grant_c;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_arbiter_n #(.N_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_a),
        .m_ack_o(m_ack_a), .m_err_o(m_err_a), .s_cyc_o(s_cyc_a), .s_stb_o(s_stb_a),
        .s_we_o(s_we_a), .s_adr_o(s_adr_a), .s_dat_o(s_dato_a), .s_sel_o(s_sel_a),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_a));

    wb_arbiter_n #(.N_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_b),
        .m_ack_o(m_ack_b), .m_err_o(m_err_b), .s_cyc_o(s_cyc_b), .s_stb_o(s_stb_b),
        .s_we_o(s_we_b), .s_adr_o(s_adr_b), .s_dat_o(s_dato_b), .s_sel_o(s_sel_b),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_b));

    wb_arbiter_n #(.N_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_c),
        .m_ack_o(m_ack_c), .m_err_o(m_err_c), .s_cyc_o(s_cyc_c), .s_stb_o(s_stb_c),
        .s_we_o(s_we_c), .s_adr_o(s_adr_c), .s_dat_o(s_dato_c), .s_sel_o(s_sel_c),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_c));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] cyc, input logic [2:0] stb, input logic ack);
        m_cyc = cyc;
        m_stb = stb;
        s_ack = ack;
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
        s_dat = '0;
        m_adr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [2:0] oh;

        // Reset values and asynchronous reset mid-transfer
        doReset();
        checkOutput("rst_grant", 32'(grant_a), 32'h0);
        checkOutput("rst_scyc", 32'(s_cyc_a), 32'h0);
        checkOutput("rst_ack", 32'(m_ack_a), 32'h0);
        checkOutput("rst_err", 32'(m_err_a), 32'h0);
        checkOutput("rst_adr", s_adr_a, 32'h0);
        applyStimulus(3'b010, 3'b010, 1'b0);
        step();
        applyStimulus(3'b010, 3'b010, 1'b0);
        checkOutput("pre_rst_grant", 32'(grant_a), 32'h2);
        checkOutput("pre_rst_scyc", 32'(s_cyc_a), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_grant", 32'(grant_a), 32'h0);
        checkOutput("async_rst_scyc", 32'(s_cyc_a), 32'h0);
        checkOutput("async_rst_ack", 32'(m_ack_a), 32'h0);
        applyStimulus(3'b111, 3'b111, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_first", 32'(grant_a), 32'h1);

        // Round-robin: every master keeps re-requesting, order 0,1,2,0
        doReset();
        for (int k = 0; k < 4; k++) begin
            oh = 3'b001 << (k % 3);
            applyStimulus(3'b111, 3'b111, 1'b0);
            checkOutput("rr_dead", 32'(grant_a), 32'h0);
            step();
            applyStimulus(3'b111, 3'b111, 1'b1);
            checkOutput("rr_grant", 32'(grant_a), 32'(oh));
            checkOutput("rr_ack", 32'(m_ack_a), 32'(oh));
            checkOutput("rr_adr", s_adr_a, 32'((k % 3) + 1) << 28);
            step();
            applyStimulus(~oh, ~oh, 1'b0);
            checkOutput("rr_release", 32'(s_cyc_a), 32'h0);
            step();
        end

        // Fixed priority: m1 beats m2; m0 cannot preempt but goes next
        doReset();
        applyStimulus(3'b110, 3'b110, 1'b0);
        checkOutput("fp_idle", 32'(grant_b), 32'h0);
        step();
        applyStimulus(3'b111, 3'b111, 1'b0);
        checkOutput("fp_first", 32'(grant_b), 32'h2);
        step();
        applyStimulus(3'b111, 3'b111, 1'b1);
        checkOutput("fp_nopreempt", 32'(grant_b), 32'h2);
        checkOutput("fp_ack", 32'(m_ack_b), 32'h2);
        step();
        applyStimulus(3'b101, 3'b101, 1'b0);
        step();
        applyStimulus(3'b101, 3'b101, 1'b0);
        checkOutput("fp_dead", 32'(grant_b), 32'h0);
        step();
        applyStimulus(3'b101, 3'b101, 1'b1);
        checkOutput("fp_next", 32'(grant_b), 32'h1);
        checkOutput("fp_next_ack", 32'(m_ack_b), 32'h1);
        step();

        // Lock: m0 keeps CYC across four beats while m1 waits
        doReset();
        m_adr[31:0] = 32'h8000_0000;
        applyStimulus(3'b011, 3'b011, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            m_adr[31:0] = 32'h8000_0000 + 32'(4 * i);
            applyStimulus(3'b011, 3'b011, 1'b1);
            checkOutput("lock_grant", 32'(grant_a), 32'h1);
            checkOutput("lock_adr", s_adr_a, 32'h8000_0000 + 32'(4 * i));
            checkOutput("lock_ack", 32'(m_ack_a), 32'h1);
            step();
            applyStimulus(3'b011, 3'b010, 1'b0);
            checkOutput("lock_gap_grant", 32'(grant_a), 32'h1);
            step();
        end
        applyStimulus(3'b010, 3'b010, 1'b0);
        checkOutput("lock_drop_cyc", 32'(s_cyc_a), 32'h0);
        step();
        applyStimulus(3'b010, 3'b010, 1'b0);
        checkOutput("lock_dead", 32'(grant_a), 32'h0);
        step();
        checkOutput("lock_m1", 32'(grant_a), 32'h2);

        // Timeout 16: err exactly on the 17th cycle after the grant
        doReset();
        applyStimulus(3'b011, 3'b011, 1'b0);
        step();
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(3'b011, 3'b011, 1'b0);
            checkOutput("to_no_err", 32'(m_err_a), 32'h0);
            step();
        end
        applyStimulus(3'b011, 3'b011, 1'b0);
        checkOutput("to_err", 32'(m_err_a), 32'h1);
        checkOutput("to_scyc", 32'(s_cyc_a), 32'h0);
        checkOutput("to_sstb", 32'(s_stb_a), 32'h0);
        checkOutput("to_grant_hold", 32'(grant_a), 32'h1);
        step();
        applyStimulus(3'b010, 3'b010, 1'b0);
        checkOutput("to_err_clear", 32'(m_err_a), 32'h0);
        checkOutput("to_grant_clear", 32'(grant_a), 32'h0);
        step();
        checkOutput("to_next", 32'(grant_a), 32'h2);

        // Ack on the would-be timeout cycle wins
        doReset();
        applyStimulus(3'b001, 3'b001, 1'b0);
        step();
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(3'b001, 3'b001, 1'b0);
            step();
        end
        applyStimulus(3'b001, 3'b001, 1'b1);
        checkOutput("race_ack", 32'(m_ack_a), 32'h1);
        checkOutput("race_no_err", 32'(m_err_a), 32'h0);
        step();
        applyStimulus(3'b001, 3'b001, 1'b0);
        checkOutput("race_after_err", 32'(m_err_a), 32'h0);
        checkOutput("race_after_cyc", 32'(s_cyc_a), 32'h1);
        step();

        // Timeout disabled: a stalled cycle waits indefinitely
        doReset();
        applyStimulus(3'b001, 3'b001, 1'b0);
        step();
        for (int c = 0; c < 40; c++) begin
            applyStimulus(3'b001, 3'b001, 1'b0);
            step();
        end
        applyStimulus(3'b001, 3'b001, 1'b0);
        checkOutput("t0_no_err", 32'(m_err_c), 32'h0);
        checkOutput("t0_cyc", 32'(s_cyc_c), 32'h1);
        checkOutput("t0_grant", 32'(grant_c), 32'h1);
        s_dat = 32'hCAFE_F00D;
        applyStimulus(3'b001, 3'b001, 1'b1);
        checkOutput("t0_ack", 32'(m_ack_c), 32'h1);
        checkOutput("t0_rdata", m_dat_c, 32'hCAFE_F00D);
        step();
        applyStimulus(3'b000, 3'b000, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
